// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (low half) and divide/remainder sequencer that
// borrows the shared EX-stage ALU one micro-op per granted cycle.
module alu_muldiv_seq #(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res_lo,
  output logic [W-1:0] res_hi,
  output logic         alu_req,
  input  logic         alu_gnt,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_out
);

  typedef enum logic [2:0] {
    IDLE, MUL_STEP, DIV_SHIFT, DIV_CMP, DIV_SUB, DZERO, DONE
  } state_t;

  localparam logic [2:0] OP_PASSB = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_SLTU  = 3'd7;

  state_t         state;
  logic [W-1:0]   opa;   // multiplicand / dividend
  logic [W-1:0]   opb;   // multiplier / divisor
  logic [W-1:0]   acc;
  logic [W-1:0]   rem;
  logic [W-1:0]   quot;
  logic           ovf;
  logic [CW-1:0]  cnt;

  logic           step_en;
  logic           last;
  logic [W-1:0]   a_shl;
  logic [W-1:0]   b_shr;
  logic           mul_bit;
  logic           div_bit;
  logic           q_bit;
  logic [W-1:0]   acc_nxt;
  logic [W-1:0]   quot_q0;
  logic [W-1:0]   quot_q1;

  // opa << cnt serves both as the shifted multiplicand and, via its MSB, as
  // dividend[W-1-cnt], so one shifter covers both operations.
  assign a_shl   = opa << cnt;
  assign b_shr   = opb >> cnt;
  assign mul_bit = b_shr[0];
  assign div_bit = a_shl[W-1];
  assign step_en = alu_req && alu_gnt;
  assign last    = (cnt == CW'(W-1));
  assign q_bit   = ovf | ~alu_out[0];
  assign acc_nxt = mul_bit ? alu_out : acc;
  assign quot_q0 = {quot[W-2:0], 1'b0};
  assign quot_q1 = {quot[W-2:0], 1'b1};

  // ALU operands are decoded from held state, so they stay put while denied.
  always_comb begin
    alu_req = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = OP_PASSB;
    case (state)
      MUL_STEP: begin
        alu_req = 1'b1;
        if (mul_bit) begin
          alu_a  = acc;
          alu_b  = a_shl;
          alu_op = OP_ADD;
        end
      end
      DIV_CMP: begin
        alu_req = 1'b1;
        alu_a   = rem;
        alu_b   = opb;
        alu_op  = OP_SLTU;
      end
      DIV_SUB: begin
        alu_req = 1'b1;
        alu_a   = rem;
        alu_b   = opb;
        alu_op  = OP_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      rem    <= '0;
      quot   <= '0;
      ovf    <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= src_a;
            opb   <= src_b;
            acc   <= '0;
            rem   <= '0;
            quot  <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= op ? ((src_b == '0) ? DZERO : DIV_SHIFT) : MUL_STEP;
          end
        end
        MUL_STEP: begin
          if (step_en) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
              res_lo <= acc_nxt;
              res_hi <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DIV_SHIFT: begin
          {ovf, rem} <= {rem, div_bit};
          state      <= DIV_CMP;
        end
        DIV_CMP: begin
          if (step_en) begin
            if (q_bit) begin
              state <= DIV_SUB;
            end else begin
              quot <= quot_q0;
              cnt  <= cnt + 1'b1;
              if (last) begin
                res_lo <= quot_q0;
                res_hi <= rem;
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                state <= DIV_SHIFT;
              end
            end
          end
        end
        DIV_SUB: begin
          // When ovf is set the true remainder exceeds W bits; the modulo-2^W
          // difference is still the correct partial remainder.
          if (step_en) begin
            rem  <= alu_out;
            quot <= quot_q1;
            cnt  <= cnt + 1'b1;
            if (last) begin
              res_lo <= quot_q1;
              res_hi <= alu_out;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= DIV_SHIFT;
            end
          end
        end
        DZERO: begin
          res_lo <= '1;
          res_hi <= opa;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
